// File: rtl/joybus_pkg.sv
// Shared Joybus timing constants and decoder state types, used by both the
// injection trigger and the injection transmitter.
package joybus_pkg;

  localparam int CYCLES_PER_US = 50;
  localparam int ZERO_THRESH   = 2 * CYCLES_PER_US;
  localparam int TIMEOUT       = 4 * CYCLES_PER_US;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    STUCK
  } jb_state_e;

  typedef enum logic [1:0] {
    CMD,
    STOP,
    RESP
  } jb_phase_e;

endpackage

// File: rtl/jb_sync_edge.sv
// Two-flop synchroniser for the raw Joybus line with single-cycle rise/fall
// pulses taken from the synchronised value and a one-cycle-delayed copy.
module jb_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // The idle Joybus line is high, so every stage resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/joybus_inj_trigger.sv
// Joybus frame decoder that counts response bits of a poll and starts the
// C-stick injection transmitter at the falling edge of the target byte.
module joybus_inj_trigger #(
  parameter int         CYCLES_PER_US = joybus_pkg::CYCLES_PER_US,
  parameter int         ZERO_THRESH   = 2 * CYCLES_PER_US,
  parameter int         TIMEOUT       = 4 * CYCLES_PER_US,
  parameter int         CMD_BITS      = 24,
  parameter logic [7:0] POLL_CMD      = 8'h40,
  parameter int         INJ_BIT       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       JB_RX,
  input  logic       inj_tx_done,
  output logic       inj_tx_start,
  output logic       inj_active,
  output logic [7:0] cmd_byte,
  output logic       frame_done,
  output logic       rx_err
);

  import joybus_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic rx_sync, rx_rise, rx_fall;

  jb_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (JB_RX),
    .sync_o (rx_sync),
    .rise_o (rx_rise),
    .fall_o (rx_fall)
  );

  jb_state_e     state_q, state_d;
  jb_phase_e     phase_q, phase_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic [CW-1:0] high_cnt_q, high_cnt_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic          dec_pend_q, dec_pend_d;
  logic          fired_q, fired_d;
  logic          inj_active_q, inj_active_d;
  logic          inj_start_q, inj_start_d;
  logic          frame_done_q, frame_done_d;
  logic          rx_err_q, rx_err_d;
  logic          dec_bit, frame_end, trigger;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    low_cnt_d    = low_cnt_q;
    high_cnt_d   = high_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    cmd_byte_d   = cmd_byte_q;
    dec_pend_d   = 1'b0;
    fired_d      = fired_q;
    inj_active_d = inj_active_q;
    inj_start_d  = 1'b0;
    frame_done_d = 1'b0;
    rx_err_d     = 1'b0;
    frame_end    = 1'b0;
    trigger      = 1'b0;
    // low_cnt already includes the rise cycle, so exactly ZERO_THRESH reads as 0.
    dec_bit      = (low_cnt_q < CW'(ZERO_THRESH));

    if (dec_pend_q) begin
      unique case (phase_q)
        CMD: begin
          if (bit_cnt_q < 6'd8) cmd_byte_d = {cmd_byte_q[6:0], dec_bit};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q + 6'd1 == 6'(CMD_BITS)) phase_d = STOP;
        end
        STOP: begin
          phase_d   = RESP;
          bit_cnt_d = '0;
        end
        default: begin
          if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
        end
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d   = LOW;
          low_cnt_d = '0;
          phase_d   = CMD;
          bit_cnt_d = '0;
          fired_d   = 1'b0;
        end
      end
      LOW: begin
        if (low_cnt_q != CW'(TIMEOUT)) low_cnt_d = low_cnt_q + CW'(1);
        if (rx_rise) begin
          state_d    = HIGH;
          high_cnt_d = '0;
          dec_pend_d = 1'b1;
        end else if (low_cnt_q == CW'(TIMEOUT - 1)) begin
          rx_err_d = 1'b1;
          state_d  = STUCK;
        end
      end
      HIGH: begin
        if (high_cnt_q != CW'(TIMEOUT)) high_cnt_d = high_cnt_q + CW'(1);
        if (rx_fall) begin
          state_d   = LOW;
          low_cnt_d = '0;
          trigger   = (phase_q == RESP) && (bit_cnt_q == 6'(INJ_BIT)) &&
                      (cmd_byte_q == POLL_CMD) && !inj_active_q && !fired_q;
        end else if (high_cnt_q == CW'(TIMEOUT - 1)) begin
          frame_done_d = 1'b1;
          frame_end    = 1'b1;
          state_d      = IDLE;
        end
      end
      STUCK: begin
        if (rx_sync) state_d = IDLE;
      end
    endcase

    // A trigger needs inj_active low, so a done pulse while idle has nothing to clear.
    if (trigger) begin
      inj_start_d  = 1'b1;
      inj_active_d = 1'b1;
      fired_d      = 1'b1;
    end else if (inj_tx_done || frame_end) begin
      inj_active_d = 1'b0;
    end
    if (frame_end) fired_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= CMD;
      low_cnt_q    <= '0;
      high_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      cmd_byte_q   <= 8'h00;
      dec_pend_q   <= 1'b0;
      fired_q      <= 1'b0;
      inj_active_q <= 1'b0;
      inj_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      low_cnt_q    <= low_cnt_d;
      high_cnt_q   <= high_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      cmd_byte_q   <= cmd_byte_d;
      dec_pend_q   <= dec_pend_d;
      fired_q      <= fired_d;
      inj_active_q <= inj_active_d;
      inj_start_q  <= inj_start_d;
      frame_done_q <= frame_done_d;
      rx_err_q     <= rx_err_d;
    end
  end

  assign inj_tx_start = inj_start_q;
  assign inj_active   = inj_active_q;
  assign cmd_byte     = cmd_byte_q;
  assign frame_done   = frame_done_q;
  assign rx_err       = rx_err_q;

endmodule
